// File: rtl/fpu_wb_regs.sv
// rtl/fpu_wb_regs.sv - Wishbone classic register file between the management SoC and the FPU core
//
// Purpose:
//   Latches operands A/B/C, the one-hot operation and the rounding mode written by
//   firmware. Launches an FPU operation by holding valid_in until valid_out returns
//   or a busy timeout expires. Captures result/flags and exposes status and an interrupt.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i        Wishbone cycle, strobe, write enable
//   wbs_sel_i, wbs_adr_i        byte lanes, byte address
//   wbs_dat_i / wbs_dat_o       write data / registered read data (valid with ack)
//   wbs_ack_o                   one-cycle acknowledge
//   a, b, c, op_in, round_mode  FPU operands, one-hot op, rounding mode
//   valid_in                    operation request, held until result or timeout
//   result, flags, valid_out    FPU result, exception flags, result strobe
//   irq_o                       level interrupt for done/timeout
module fpu_wb_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [31:0] c,
    output logic [11:0] op_in,
    output logic        valid_in,
    output logic [2:0]  round_mode,
    input  logic [31:0] result,
    input  logic [4:0]  flags,
    input  logic        valid_out,
    output logic        irq_o
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  flags_q, flags_d;
    logic [12:0] op_q, op_d;
    logic [2:0]  rm_q, rm_d;
    logic [1:0]  irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        tmo_q, tmo_d;
    logic        ovr_q, ovr_d;
    logic        irq_q, irq_d;
    logic [31:0] cnt_q, cnt_d;

    logic        req, hit, wr, rd, busy, capture, tmo_hit;
    logic        data_reg_wr, wr_ok;
    logic [2:0]  w1c;
    logic [7:0]  off;
    logic [31:0] rdata;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = sel[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return m;
    endfunction

    always_comb begin
        // An ack cycle never samples a new request, which forces the idle cycle
        // between acks when stb is held.
        req     = wbs_cyc_i & wbs_stb_i & ~ack_q;
        hit     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]) && (wbs_adr_i[1:0] == 2'b00);
        off     = wbs_adr_i[7:0];
        wr      = req & wbs_we_i & hit;
        rd      = req & ~wbs_we_i & hit;
        busy    = op_q[12];
        capture = valid_out & busy;
        // A result arriving on the last allowed cycle still counts as a result.
        tmo_hit = busy & ~capture & (cnt_q == 32'(TIMEOUT - 1));

        data_reg_wr = wr & ((off == 8'h00) || (off == 8'h04) || (off == 8'h08) ||
                            (off == 8'h1C) || (off == 8'h24));
        // busy is the pre-update value, so a write racing a capture is an overrun.
        wr_ok = wr & ~busy;
        w1c   = (wr && (off == 8'h14) && wbs_sel_i[0]) ? wbs_dat_i[3:1] : 3'b000;

        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        op_d     = op_q;
        rm_d     = rm_q;
        irq_en_d = irq_en_q;
        result_d = result_q;
        flags_d  = flags_q;

        if (wr_ok) begin
            case (off)
                8'h00: a_d = merge(a_q, wbs_dat_i, wbs_sel_i);
                8'h04: b_d = merge(b_q, wbs_dat_i, wbs_sel_i);
                8'h08: c_d = merge(c_q, wbs_dat_i, wbs_sel_i);
                8'h1C: begin
                    if (wbs_sel_i[0]) op_d[7:0]  = wbs_dat_i[7:0];
                    if (wbs_sel_i[1]) op_d[12:8] = wbs_dat_i[12:8];
                end
                8'h24: if (wbs_sel_i[0]) rm_d = wbs_dat_i[2:0];
                default: ;
            endcase
        end
        // IRQ_EN is not an FPU-side register, so it stays writable while busy.
        if (wr && (off == 8'h18) && wbs_sel_i[0]) irq_en_d = wbs_dat_i[1:0];

        if (capture) begin
            result_d = result;
            flags_d  = flags;
            op_d[12] = 1'b0;
        end
        if (tmo_hit) op_d[12] = 1'b0;

        // Set beats clear when an event and its W1C land together.
        done_d = (done_q & ~w1c[0]) | capture;
        tmo_d  = (tmo_q  & ~w1c[1]) | tmo_hit;
        ovr_d  = (ovr_q  & ~w1c[2]) | (data_reg_wr & busy);

        cnt_d = (busy & ~capture & ~tmo_hit) ? cnt_q + 32'd1 : 32'd0;

        case (off)
            8'h00:   rdata = a_q;
            8'h04:   rdata = b_q;
            8'h08:   rdata = c_q;
            8'h0C:   rdata = result_q;
            8'h10:   rdata = {27'd0, flags_q};
            8'h14:   rdata = {28'd0, ovr_q, tmo_q, done_q, busy};
            8'h18:   rdata = {30'd0, irq_en_q};
            8'h1C:   rdata = {19'd0, op_q};
            8'h24:   rdata = {29'd0, rm_q};
            default: rdata = 32'd0;
        endcase

        ack_d = req;
        dat_d = rd ? rdata : 32'd0;
        irq_d = (done_q & irq_en_q[0]) | (tmo_q & irq_en_q[1]);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            c_q      <= 32'd0;
            result_q <= 32'd0;
            flags_q  <= 5'd0;
            op_q     <= 13'd0;
            rm_q     <= 3'd0;
            irq_en_q <= 2'd0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
            cnt_q    <= 32'd0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            op_q     <= op_d;
            rm_q     <= rm_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            ovr_q    <= ovr_d;
            irq_q    <= irq_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign a          = a_q;
    assign b          = b_q;
    assign c          = c_q;
    assign op_in      = op_q[11:0];
    assign valid_in   = op_q[12];
    assign round_mode = rm_q;
    assign irq_o      = irq_q;

endmodule
